// File: rtl/frq_err_pkg.sv
// Shared types and helpers for the multi-channel frequency error arbiter.
// Helpers work on a fixed 32-bit signed carrier and take the active width as an argument.
package frq_err_pkg;

  typedef enum logic {
    CH_OK  = 1'b0,
    CH_ERR = 1'b1
  } ch_state_e;

  localparam logic [1:0] STEP_P1  = 2'b01;
  localparam logic [1:0] STEP_M1  = 2'b11;
  localparam logic [1:0] STEP_Z   = 2'b00;
  localparam logic [1:0] STEP_ILL = 2'b10;

  localparam int FN_W = 32;

  // Symmetric clamp to +/-(2^(w-1)-1) so the magnitude always fits in w-1 bits.
  function automatic logic signed [FN_W-1:0] sat_add(input logic signed [FN_W-1:0] a,
                                                     input logic signed [FN_W-1:0] b,
                                                     input int w);
    logic signed [FN_W-1:0] lim;
    logic signed [FN_W-1:0] sum;
    lim = $signed((32'd1 << (w - 1)) - 32'd1);
    sum = a + b;
    if (sum > lim) sat_add = lim;
    else if (sum < -lim) sat_add = -lim;
    else sat_add = sum;
  endfunction

  function automatic logic [FN_W-1:0] abs_val(input logic signed [FN_W-1:0] a);
    if (a < 0) abs_val = $unsigned(-a);
    else abs_val = $unsigned(a);
  endfunction

endpackage

// File: rtl/frq_err_arb_mc_ch.sv
// One monitored channel: signed shift accumulator, dirty flag, clean-window
// counter, running/captured peak and the OK/ERR state machine.
module frq_err_ch
  import frq_err_pkg::*;
#(
  parameter int W  = 6,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          win_end,
  input  logic          rot_vld,
  input  logic [1:0]    rot_step,
  input  logic [W-2:0]  rot_max,
  input  logic          sticky,
  input  logic [CW-1:0] clr_cnt,
  input  logic          err_clr,
  output logic          error,
  output logic          err_nxt,
  output logic [W-2:0]  peak
);

  logic signed [W-1:0]    acc_q, acc_d, acc_nxt;
  logic [W-2:0]           mag_nxt, run_q, run_d, run_max, peak_q, peak_d;
  logic                   dirty_q, dirty_d, win_dirty, ill, viol;
  logic [CW-1:0]          clean_q, clean_d;
  logic [CW:0]            clean_inc;
  logic signed [FN_W-1:0] step_ext;
  ch_state_e              state_q, state_d;

  always_comb begin
    ill      = rot_vld && (rot_step == STEP_ILL);
    step_ext = '0;
    if (rot_step == STEP_P1) step_ext = 32'sd1;
    else if (rot_step == STEP_M1) step_ext = -32'sd1;

    acc_nxt   = rot_vld ? W'(sat_add({{(FN_W-W){acc_q[W-1]}}, acc_q}, step_ext, W)) : acc_q;
    mag_nxt   = (W-1)'(abs_val({{(FN_W-W){acc_nxt[W-1]}}, acc_nxt}));
    viol      = (mag_nxt >= rot_max) || ill;
    win_dirty = dirty_q || viol;

    // A step landing on the window-end cycle still counts toward the closing window.
    run_max = (mag_nxt > run_q) ? mag_nxt : run_q;
    acc_d   = win_end ? '0 : acc_nxt;
    dirty_d = win_end ? 1'b0 : win_dirty;
    run_d   = win_end ? '0 : run_max;
    peak_d  = win_end ? run_max : peak_q;

    clean_inc = {1'b0, clean_q} + (CW+1)'(1);
    state_d   = state_q;
    clean_d   = clean_q;
    if (err_clr) begin
      state_d = CH_OK;
      clean_d = '0;
    end else if (state_q == CH_OK) begin
      if (viol) begin
        state_d = CH_ERR;
        clean_d = '0;
      end
    end else if (!sticky && win_end) begin
      if (clr_cnt == '0) begin
        state_d = CH_OK;
      end else if (win_dirty) begin
        clean_d = '0;
      end else if (clean_inc == {1'b0, clr_cnt}) begin
        state_d = CH_OK;
        clean_d = '0;
      end else begin
        clean_d = clean_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      dirty_q <= 1'b0;
      run_q   <= '0;
      peak_q  <= '0;
      clean_q <= '0;
      state_q <= CH_OK;
    end else if (en) begin
      acc_q   <= acc_d;
      dirty_q <= dirty_d;
      run_q   <= run_d;
      peak_q  <= peak_d;
      clean_q <= clean_d;
      state_q <= state_d;
    end
  end

  assign error   = (state_q == CH_ERR);
  assign err_nxt = (state_d == CH_ERR);
  assign peak    = peak_q;

endmodule

// File: rtl/frq_err_arb_mc.sv
// Multi-channel frequency error arbiter: shared window timer, per-channel
// monitors, registered any_error and win_done pulse.
module frq_err_arb_mc
  import frq_err_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int ROT_SH_CTR_SIZE = 6,
  parameter int WIN_CNT_SIZE    = 16,
  parameter int CLR_CNT_SIZE    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [WIN_CNT_SIZE-1:0]               win_len,
  input  logic                                  timeout,
  input  logic [NUM_CH-1:0]                     rot_vld,
  input  logic [2*NUM_CH-1:0]                   rot_step,
  input  logic [ROT_SH_CTR_SIZE-2:0]            rot_max,
  input  logic                                  sticky,
  input  logic [CLR_CNT_SIZE-1:0]               clr_cnt,
  input  logic                                  err_clr,
  output logic [NUM_CH-1:0]                     error,
  output logic                                  any_error,
  output logic                                  win_done,
  output logic [(ROT_SH_CTR_SIZE-1)*NUM_CH-1:0] peak_sh,
  output logic [NUM_CH-1:0]                     dbg_ch_state
);

  localparam int MW = ROT_SH_CTR_SIZE - 1;

  logic [WIN_CNT_SIZE-1:0] win_cnt_q, win_cnt_d;
  logic                    win_end, win_done_q, any_error_q;
  logic [NUM_CH-1:0]       err_nxt;

  // The >= compare closes the window at once if win_len shrinks below the current count.
  always_comb begin
    win_end   = en && (timeout ||
                ((win_len != '0) && (win_cnt_q >= win_len - WIN_CNT_SIZE'(1))));
    win_cnt_d = win_end ? '0 : win_cnt_q + WIN_CNT_SIZE'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q   <= '0;
      win_done_q  <= 1'b0;
      any_error_q <= 1'b0;
    end else if (en) begin
      win_cnt_q   <= win_cnt_d;
      win_done_q  <= win_end;
      any_error_q <= |err_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    frq_err_ch #(
      .W  (ROT_SH_CTR_SIZE),
      .CW (CLR_CNT_SIZE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .win_end  (win_end),
      .rot_vld  (rot_vld[i]),
      .rot_step (rot_step[2*i +: 2]),
      .rot_max  (rot_max),
      .sticky   (sticky),
      .clr_cnt  (clr_cnt),
      .err_clr  (err_clr),
      .error    (error[i]),
      .err_nxt  (err_nxt[i]),
      .peak     (peak_sh[MW*i +: MW])
    );
  end

  assign win_done     = win_done_q;
  assign any_error    = any_error_q;
  assign dbg_ch_state = error;

endmodule

// File: tb/tb_frq_err_arb_mc.sv
// Bench for frq_err_arb_mc: integer reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_frq_err_arb_mc;
  localparam int NUM_CH = 4;
  localparam int RW     = 6;
  localparam int MW     = RW - 1;
  localparam int WCW    = 16;
  localparam int CCW    = 3;
  localparam int LIM    = (1 << (RW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic [WCW-1:0]       win_len = '0;
  logic                 timeout = 1'b0;
  logic [NUM_CH-1:0]    rot_vld = '0;
  logic [2*NUM_CH-1:0]  rot_step = '0;
  logic [MW-1:0]        rot_max = '0;
  logic                 sticky = 1'b0;
  logic [CCW-1:0]       clr_cnt = '0;
  logic                 err_clr = 1'b0;
  logic [NUM_CH-1:0]    error;
  logic                 any_error;
  logic                 win_done;
  logic [MW*NUM_CH-1:0] peak_sh;
  logic [NUM_CH-1:0]    dbg_ch_state;

  always #5 clk = ~clk;

  frq_err_arb_mc #(
    .NUM_CH(NUM_CH), .ROT_SH_CTR_SIZE(RW), .WIN_CNT_SIZE(WCW), .CLR_CNT_SIZE(CCW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .timeout(timeout),
    .rot_vld(rot_vld), .rot_step(rot_step), .rot_max(rot_max), .sticky(sticky),
    .clr_cnt(clr_cnt), .err_clr(err_clr), .error(error), .any_error(any_error),
    .win_done(win_done), .peak_sh(peak_sh), .dbg_ch_state(dbg_ch_state)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_acc[NUM_CH], m_run[NUM_CH], m_peak[NUM_CH], m_clean[NUM_CH];
  bit m_err[NUM_CH], m_dirty[NUM_CH];
  int m_cnt, cyc;
  bit m_done, m_any;

  initial begin : model
    int s, nx, a;
    bit ill, viol, wend, wd;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_acc[c] = 0; m_run[c] = 0; m_peak[c] = 0; m_clean[c] = 0;
          m_err[c] = 0; m_dirty[c] = 0;
        end
        m_cnt = 0; m_done = 0; m_any = 0; cyc = 0;
      end else begin
        if (en) begin
          wend = timeout || (win_len != 0 && m_cnt >= int'(win_len) - 1);
          for (int c = 0; c < NUM_CH; c++) begin
            s = 0; ill = 0;
            if (rot_vld[c]) begin
              case (rot_step[2*c +: 2])
                2'b01:   s = 1;
                2'b11:   s = -1;
                2'b10:   ill = 1;
                default: s = 0;
              endcase
            end
            nx = m_acc[c] + s;
            if (nx > LIM) nx = LIM;
            if (nx < -LIM) nx = -LIM;
            a = (nx < 0) ? -nx : nx;
            viol = (a >= int'(rot_max)) || ill;
            wd = m_dirty[c] || viol;
            if (err_clr) begin
              m_err[c] = 0; m_clean[c] = 0;
            end else if (!m_err[c]) begin
              if (viol) begin m_err[c] = 1; m_clean[c] = 0; end
            end else if (!sticky && wend) begin
              if (clr_cnt == 0) m_err[c] = 0;
              else if (wd) m_clean[c] = 0;
              else begin
                m_clean[c]++;
                if (m_clean[c] == int'(clr_cnt)) begin m_err[c] = 0; m_clean[c] = 0; end
              end
            end
            if (a > m_run[c]) m_run[c] = a;
            if (wend) begin
              m_peak[c] = m_run[c]; m_run[c] = 0; m_acc[c] = 0; m_dirty[c] = 0;
            end else begin
              m_acc[c] = nx; m_dirty[c] = wd;
            end
          end
          m_cnt = wend ? 0 : (m_cnt + 1) % (1 << WCW);
          m_done = wend;
          m_any = 0;
          for (int c = 0; c < NUM_CH; c++) m_any = m_any | m_err[c];
        end
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [NUM_CH-1:0]    exp_err;
    logic [MW*NUM_CH-1:0] exp_pk;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < NUM_CH; c++) begin
          exp_err[c] = m_err[c];
          exp_pk[MW*c +: MW] = MW'(m_peak[c]);
        end
        chk("m_error", int'(error), int'(exp_err));
        chk("m_dbg_state", int'(dbg_ch_state), int'(exp_err));
        chk("m_any_error", int'(any_error), int'(m_any));
        chk("m_win_done", int'(win_done), int'(m_done));
        chk("m_peak_sh", int'(peak_sh), int'(exp_pk));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic set_ch(input int c, input logic vld, input logic [1:0] st);
    rot_vld[c] = vld;
    rot_step[2*c +: 2] = st;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; rot_vld = '0; rot_step = '0; timeout = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_error", int'(error), 0);
    chk("rst_any_error", int'(any_error), 0);
    chk("rst_win_done", int'(win_done), 0);
    chk("rst_peak_sh", int'(peak_sh), 0);
    rst = 1'b0;
  endtask

  function automatic int pk(input int c);
    return int'(peak_sh[MW*c +: MW]);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int pulses;

    // drift trip with auto-clear after two clean windows
    do_reset();
    win_len = 100; rot_max = 4; sticky = 0; clr_cnt = 2; en = 1;
    at(10);  set_ch(0, 1, 2'b01);
    at(13);  chk("t1_no_err_yet", int'(error[0]), 0);
    at(14);  chk("t1_err_set", int'(error[0]), 1); chk("t1_any", int'(any_error), 1);
    at(15);  set_ch(0, 0, 2'b00);
    at(99);  chk("t1_no_done_early", int'(win_done), 0);
    at(100); chk("t1_win_done", int'(win_done), 1); chk("t1_peak0", pk(0), 5);
             chk("t1_err_dirty_win", int'(error[0]), 1);
    at(299); chk("t1_err_before_clr", int'(error[0]), 1);
    at(300); chk("t1_err_autoclr", int'(error[0]), 0);

    // illegal step adds nothing and only hits its own channel
    at(310); set_ch(2, 1, 2'b01);
    at(312); set_ch(2, 0, 2'b00);
    at(320); set_ch(2, 1, 2'b10);
    at(321); chk("t2_ill_err", int'(error), 4'b0100); set_ch(2, 1, 2'b01);
    at(322); set_ch(2, 0, 2'b00);
    at(400); chk("t2_peak2", pk(2), 3); chk("t2_peak0", pk(0), 0);

    // legacy clear and mid-window win_len shrink
    do_reset();
    win_len = 100; rot_max = 4; sticky = 0; clr_cnt = 0; en = 1;
    at(50);  set_ch(1, 1, 2'b10);
    at(51);  set_ch(1, 0, 2'b00); chk("t3_err", int'(error[1]), 1);
    at(99);  set_ch(1, 1, 2'b10); chk("t3_err_held", int'(error[1]), 1);
    at(100); set_ch(1, 0, 2'b00); chk("t3_legacy_clr", int'(error[1]), 0);
    at(150); chk("t3_no_done", int'(win_done), 0); win_len = 30;
    at(151); chk("t3_shrink_done", int'(win_done), 1);

    // sticky hold, err_clr beats same-cycle violation
    do_reset();
    win_len = 20; rot_max = 4; sticky = 1; clr_cnt = 1; en = 1;
    at(5);   set_ch(1, 1, 2'b10);
    at(6);   set_ch(1, 0, 2'b00); chk("t4_err", int'(error[1]), 1);
    at(62);  set_ch(3, 1, 2'b01);
    at(64);  set_ch(3, 0, 2'b00);
    at(70);  chk("t4_sticky_held", int'(error[1]), 1); set_ch(1, 1, 2'b10); err_clr = 1;
    at(71);  set_ch(1, 0, 2'b00); err_clr = 0; chk("t4_clr_wins", int'(error[1]), 0);
    at(80);  chk("t4_acc_untouched", pk(3), 2); set_ch(1, 1, 2'b10);
    at(81);  set_ch(1, 0, 2'b00); chk("t4_reset_err", int'(error[1]), 1);

    // saturation at -31
    do_reset();
    win_len = 100; rot_max = 31; sticky = 0; clr_cnt = 1; en = 1;
    at(0);   set_ch(0, 1, 2'b11);
    at(40);  set_ch(0, 0, 2'b00);
    at(100); chk("t5_sat_peak", pk(0), 31);

    // rot_max = 0 flags on the first cycle
    do_reset();
    win_len = 100; rot_max = 0; sticky = 0; clr_cnt = 1; en = 1;
    at(1);   chk("t5_max0_err", int'(error), 4'b1111); chk("t5_max0_any", int'(any_error), 1);

    // enable freeze, external timeout, win_len=0, async reset
    do_reset();
    win_len = 100; rot_max = 20; sticky = 0; clr_cnt = 1; en = 1;
    at(3);   set_ch(1, 1, 2'b10);
    at(4);   set_ch(1, 0, 2'b00);
    at(5);   set_ch(0, 1, 2'b01);
    at(10);  set_ch(0, 0, 2'b00);
    at(20);  en = 0;
    at(25);  set_ch(0, 1, 2'b01); timeout = 1; err_clr = 1;
    at(26);  set_ch(0, 0, 2'b00); timeout = 0; err_clr = 0;
    at(39);  chk("t6_frozen_done", int'(win_done), 0); chk("t6_frozen_err", int'(error[1]), 1);
    at(40);  en = 1;
    at(57);  timeout = 1;
    at(58);  timeout = 0; chk("t6_timeout_done", int'(win_done), 1); chk("t6_peak0", pk(0), 5);
    at(60);  set_ch(0, 1, 2'b01);
    at(61);  set_ch(0, 0, 2'b00);
    at(158); chk("t6_acc_cleared", pk(0), 1); chk("t6_err1_clr", int'(error[1]), 0);
             chk("t6_done2", int'(win_done), 1);
    at(160); win_len = 0;
    pulses = 0;
    for (int k = 161; k <= 400; k++) begin
      at(k);
      pulses += int'(win_done);
    end
    chk("t6_no_done_len0", pulses, 0);
    at(405); set_ch(0, 1, 2'b10);
    at(406); set_ch(0, 0, 2'b00);
    at(410); chk("t6_pre_rst_err", int'(error), 4'b0001); chk("t6_pre_rst_peak", pk(0), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_error", int'(error), 0);
    chk("t6_async_any", int'(any_error), 0);
    chk("t6_async_peak", int'(peak_sh), 0);
    chk("t6_async_done", int'(win_done), 0);
    @(negedge clk);
    rst = 1'b0; en = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
